turnstile_action_encoder: RTL and testbench
===========================================

Name: turnstile_action_encoder

Overview:
- Upstream stage of the gate branching automaton. Converts raw turnstile inputs into the automaton's action stream (Pay = 0, Turn = 1).
- Raw inputs are coin insertions carrying credit values and the mechanical arm turn sensor.
- Accumulates coin credit until the fare is covered and debounces the turn sensor.
- Queues the resulting action codes in a small FIFO, presented with a valid/ready handshake to the automaton driver.

Parameters:
- FARE, 4, credit units consumed per Pay action; must be 1..2^CREDIT_W-1.
- CREDIT_W, 4, width of coin_value and the credit register.
- DEBOUNCE, 3, consecutive stable synchronized samples required to change the debounced turn level (>=1).
- DEPTH, 4, action FIFO entries; fixed at 4 in this revision.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- coin_valid  in  1  coin inserted this cycle.
- coin_value  in  CREDIT_W  credit of the inserted coin; ignored when coin_valid=0.
- turn_raw  in  1  asynchronous, bouncy arm sensor.
- act_ready  in  1  consumer accepts the head action.
- act_valid  out  1  FIFO non-empty.
- act_code  out  1  head action: 0 = Pay, 1 = Turn.
- credit  out  CREDIT_W  current accumulated credit.
- fifo_count  out  3  entries held, 0..4.
- overflow  out  1  sticky; set when any event is dropped.

Behaviour:
- Reset (async assert, sync release): credit=0, FIFO empty, act_valid=0, act_code=0, fifo_count=0, overflow=0, synchronizer flops=0, debounced level=0, debounce counter=0.
- Turn synchronizer: two flops on turn_raw.
  - Debounce counter increments while the synchronized value differs from the debounced level.
  - The counter clears when they match.
  - When the count reaches DEBOUNCE, the debounced level takes the synchronized value and the counter clears.
  - A 0->1 transition of the debounced level raises turn_evt for one cycle. A 1->0 transition raises nothing.
  - Latency: a clean turn_raw rise produces turn_evt DEBOUNCE+2 cycles later.
- Credit:
  - pay_evt is asserted in a cycle when the registered credit >= FARE. The decision uses the pre-update credit.
  - Next credit = credit - (pay accepted ? FARE : 0) + (coin_valid ? coin_value : 0), saturated at 2^CREDIT_W-1. Use a CREDIT_W+1-bit intermediate.
  - If pay_evt cannot be enqueued, the FARE is not deducted and credit is retained.
  - Only one Pay per cycle is issued, even when credit >= 2*FARE. A remaining surplus issues on following cycles.
- FIFO enqueue:
  - Same-cycle pay_evt and turn_evt are enqueued Pay first, then Turn.
  - Room is computed as DEPTH - fifo_count. A same-cycle pop does not free space.
  - If room is 1 and both events fire, Pay is enqueued and Turn is dropped; overflow is set.
  - If room is 0, turn_evt is dropped and overflow is set. pay_evt is deferred, not dropped, and overflow is not set for it.
- FIFO dequeue:
  - A pop occurs when act_valid && act_ready.
  - act_code always reflects the head entry and holds stable while act_valid=1 and act_ready=0.
  - Push and pop in the same cycle are both performed; fifo_count is updated net.
- Enqueue-to-output latency: an event enqueued in cycle N is visible on act_valid/act_code in cycle N+1.
- Pointers: 2-bit read/write pointers that wrap modulo 4. fifo_count is held explicitly.
- overflow clears only on reset.
- Reset asserted mid-operation discards the queued actions and the credit immediately, without waiting for a clock edge.

Optional Feature:
- Macro TURNSTILE_STATS_EN.
- Defined:
  - Adds output pay_total [15:0] and output turn_total [15:0].
  - Each counts actions popped from the FIFO by type.
  - Both wrap at 16 bits and reset to 0 on rst_n.
- Undefined:
  - Ports and counters are absent.
  - All other behaviour is identical.

Test Plan:
- Reset, then coins 2,2 on consecutive cycles with act_ready=1 -> credit shows 2 then 4; act_valid=1 with act_code=0 for one cycle; credit returns to 0.
- turn_raw bounce pattern 1,0,1,0 then held 1, DEBOUNCE=3 -> exactly one Turn (act_code=1) queued; no Turn queued on release.
- act_ready=0; credit reaches 15 via coins; Pay plus turns -> fifo_count stops at 4; extra turns set overflow=1; credit holds >= FARE; raising act_ready drains and the remaining Pays then issue.
- pay_evt and turn_evt in the same cycle with an empty FIFO -> fifo_count=2; pops return 0 then 1.
- Assert rst_n low between clock edges with 3 entries queued and credit=7 -> act_valid, fifo_count and credit go to 0 immediately.
- With TURNSTILE_STATS_EN: pop 3 Pays and 2 Turns -> pay_total=3, turn_total=2.

Source files
------------

// File: rtl/turnstile_action_encoder.sv
// Turnstile front end: coin credit accumulation, turn-sensor debounce and a 4-entry action FIFO (Pay=0, Turn=1).
// Optional pop statistics counters are enabled by defining TURNSTILE_STATS_EN.
module turnstile_action_encoder #(
    parameter int FARE     = 4,
    parameter int CREDIT_W = 4,
    parameter int DEBOUNCE = 3,
    parameter int DEPTH    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                coin_valid,
    input  logic [CREDIT_W-1:0] coin_value,
    input  logic                turn_raw,
    input  logic                act_ready,
    output logic                act_valid,
    output logic                act_code,
    output logic [CREDIT_W-1:0] credit,
    output logic [2:0]          fifo_count,
    output logic                overflow
`ifdef TURNSTILE_STATS_EN
    ,
    output logic [15:0]         pay_total,
    output logic [15:0]         turn_total
`endif
);

    localparam int CNT_W = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE);
    localparam logic [CNT_W-1:0]  DEB_LAST   = CNT_W'(DEBOUNCE - 1);
    localparam logic [CREDIT_W:0] FARE_X     = (CREDIT_W + 1)'(FARE);
    localparam logic [CREDIT_W:0] CREDIT_MAX = {1'b0, {CREDIT_W{1'b1}}};
    localparam logic [2:0]        DEPTH_X    = 3'(DEPTH);

    logic             sync1;
    logic             sync2;
    logic             deb_level;
    logic [CNT_W-1:0] deb_cnt;
    logic             turn_evt;

    logic [3:0]       fifo_mem;
    logic [1:0]       wr_ptr;
    logic [1:0]       rd_ptr;

    logic             pay_evt;
    logic [2:0]       room;
    logic             pay_push;
    logic             turn_push;
    logic             turn_drop;
    logic             pop;
    logic [2:0]       push_cnt;
    logic [1:0]       turn_slot;
    logic [CREDIT_W:0] credit_sum;
    logic [CREDIT_W-1:0] credit_next;

    // The debounced level only moves after DEBOUNCE consecutive disagreeing samples;
    // turn_evt is registered so it lands on the cycle the level rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            deb_level <= 1'b0;
            deb_cnt   <= '0;
            turn_evt  <= 1'b0;
        end else begin
            sync1    <= turn_raw;
            sync2    <= sync1;
            turn_evt <= 1'b0;
            if (sync2 != deb_level) begin
                if (deb_cnt == DEB_LAST) begin
                    deb_level <= sync2;
                    deb_cnt   <= '0;
                    turn_evt  <= sync2;
                end else begin
                    deb_cnt <= deb_cnt + CNT_W'(1);
                end
            end else begin
                deb_cnt <= '0;
            end
        end
    end

    // Room ignores a same-cycle pop; Pay takes the first free slot, Turn the next.
    always_comb begin
        pay_evt   = ({1'b0, credit} >= FARE_X);
        room      = DEPTH_X - fifo_count;
        pay_push  = pay_evt && (room != 3'd0);
        turn_push = turn_evt && (room >= (pay_push ? 3'd2 : 3'd1));
        turn_drop = turn_evt && !turn_push;
        pop       = act_valid && act_ready;
        push_cnt  = {2'b00, pay_push} + {2'b00, turn_push};
        turn_slot = pay_push ? (wr_ptr + 2'd1) : wr_ptr;

        credit_sum = {1'b0, credit}
                   - (pay_push   ? FARE_X : '0)
                   + (coin_valid ? {1'b0, coin_value} : '0);
        if (credit_sum > CREDIT_MAX) begin
            credit_next = CREDIT_MAX[CREDIT_W-1:0];
        end else begin
            credit_next = credit_sum[CREDIT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit     <= '0;
            fifo_mem   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            credit <= credit_next;
            if (pay_push) begin
                fifo_mem[wr_ptr] <= 1'b0;
            end
            if (turn_push) begin
                fifo_mem[turn_slot] <= 1'b1;
            end
            wr_ptr     <= wr_ptr + push_cnt[1:0];
            rd_ptr     <= rd_ptr + {1'b0, pop};
            fifo_count <= fifo_count + push_cnt - {2'b00, pop};
            if (turn_drop) begin
                overflow <= 1'b1;
            end
        end
    end

    assign act_valid = (fifo_count != 3'd0);
    assign act_code  = act_valid & fifo_mem[rd_ptr];

`ifdef TURNSTILE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pay_total  <= '0;
            turn_total <= '0;
        end else if (pop) begin
            if (act_code) begin
                turn_total <= turn_total + 16'd1;
            end else begin
                pay_total <= pay_total + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_turnstile_action_encoder.sv
// Directed self-checking bench for turnstile_action_encoder with default parameters.
// Define TURNSTILE_STATS_EN to also check the pop statistics counters.
module tb_turnstile_action_encoder;

    logic       clk;
    logic       rst_n;
    logic       coin_valid;
    logic [3:0] coin_value;
    logic       turn_raw;
    logic       act_ready;
    logic       act_valid;
    logic       act_code;
    logic [3:0] credit;
    logic [2:0] fifo_count;
    logic       overflow;
`ifdef TURNSTILE_STATS_EN
    logic [15:0] pay_total;
    logic [15:0] turn_total;
`endif

    int compared;
    int mismatched;

    turnstile_action_encoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .coin_valid (coin_valid),
        .coin_value (coin_value),
        .turn_raw   (turn_raw),
        .act_ready  (act_ready),
        .act_valid  (act_valid),
        .act_code   (act_code),
        .credit     (credit),
        .fifo_count (fifo_count),
        .overflow   (overflow)
`ifdef TURNSTILE_STATS_EN
        ,
        .pay_total  (pay_total),
        .turn_total (turn_total)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // One clock edge; inputs change and outputs are sampled 1 ns after it.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic cv, input logic [3:0] val, input logic tr, input logic rdy);
        coin_valid = cv;
        coin_value = val;
        turn_raw   = tr;
        act_ready  = rdy;
        tick(1);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        coin_valid = 1'b0;
        coin_value = 4'd0;
        turn_raw   = 1'b0;
        act_ready  = 1'b0;
        tick(3);
        checkOutput("rst_valid",    32'(act_valid),  32'd0);
        checkOutput("rst_code",     32'(act_code),   32'd0);
        checkOutput("rst_credit",   32'(credit),     32'd0);
        checkOutput("rst_count",    32'(fifo_count), 32'd0);
        checkOutput("rst_overflow", 32'(overflow),   32'd0);
        rst_n = 1'b1;
        tick(2);

        $display("[TB] coins 2,2 then single Pay");
        applyStimulus(1'b1, 4'd2, 1'b0, 1'b1);
        checkOutput("coin_credit2", 32'(credit), 32'd2);
        applyStimulus(1'b1, 4'd2, 1'b0, 1'b1);
        checkOutput("coin_credit4", 32'(credit), 32'd4);
        checkOutput("coin_novalid", 32'(act_valid), 32'd0);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);
        checkOutput("pay_valid",  32'(act_valid),  32'd1);
        checkOutput("pay_code",   32'(act_code),   32'd0);
        checkOutput("pay_credit", 32'(credit),     32'd0);
        checkOutput("pay_count",  32'(fifo_count), 32'd1);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);
        checkOutput("pay_popped", 32'(act_valid), 32'd0);

        $display("[TB] bouncy turn sensor");
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
        checkOutput("turn_early", 32'(fifo_count), 32'd0);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
        checkOutput("turn_count", 32'(fifo_count), 32'd1);
        checkOutput("turn_code",  32'(act_code),   32'd1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
        checkOutput("release_count", 32'(fifo_count), 32'd1);
        checkOutput("hold_code",     32'(act_code),   32'd1);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);
        checkOutput("turn_popped", 32'(fifo_count), 32'd0);

        $display("[TB] same-cycle Pay and Turn");
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
        applyStimulus(1'b1, 4'd4, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
        checkOutput("both_count",  32'(fifo_count), 32'd2);
        checkOutput("both_head",   32'(act_code),   32'd0);
        checkOutput("both_credit", 32'(credit),     32'd0);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b1);
        checkOutput("both_pop1_count", 32'(fifo_count), 32'd1);
        checkOutput("both_pop1_code",  32'(act_code),   32'd1);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b1);
        checkOutput("both_pop2_valid", 32'(act_valid), 32'd0);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);
        checkOutput("both_idle", 32'(act_valid), 32'd0);
`ifdef TURNSTILE_STATS_EN
        checkOutput("stats_pay",  32'(pay_total),  32'd2);
        checkOutput("stats_turn", 32'(turn_total), 32'd2);
`endif

        $display("[TB] full FIFO, deferred Pay and dropped Turn");
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 4'd15, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
        checkOutput("full_count",    32'(fifo_count), 32'd4);
        checkOutput("full_credit",   32'(credit),     32'd15);
        checkOutput("defer_no_ovf",  32'(overflow),   32'd0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
        checkOutput("drop_overflow", 32'(overflow),   32'd1);
        checkOutput("drop_count",    32'(fifo_count), 32'd4);
        checkOutput("drop_credit",   32'(credit),     32'd15);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);
        checkOutput("drain_count",    32'(fifo_count), 32'd0);
        checkOutput("drain_credit",   32'(credit),     32'd3);
        checkOutput("drain_overflow", 32'(overflow),   32'd1);

        $display("[TB] asynchronous reset mid-operation");
        applyStimulus(1'b1, 4'd9, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd3, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd4, 1'b0, 1'b0);
        checkOutput("pre_rst_count",  32'(fifo_count), 32'd3);
        checkOutput("pre_rst_credit", 32'(credit),     32'd7);
        coin_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_valid",    32'(act_valid),  32'd0);
        checkOutput("async_count",    32'(fifo_count), 32'd0);
        checkOutput("async_credit",   32'(credit),     32'd0);
        checkOutput("async_overflow", 32'(overflow),   32'd0);
        tick(2);
        rst_n = 1'b1;
        applyStimulus(1'b1, 4'd3, 1'b0, 1'b1);
        checkOutput("post_rst_credit", 32'(credit),    32'd3);
        checkOutput("post_rst_valid",  32'(act_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
